// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - state encoding and width helpers shared by the audio mixer
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Headroom for CHANNELS full-scale products summed into one accumulator.
  function automatic int acc_width(input int iw, input int gw, input int ch);
    return iw + gw + clog2(ch);
  endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// rtl/audio_mixer_if.sv - sample request, source bus and mixed output bundle
interface audio_mixer_if #(
  parameter int CHANNELS = 8,
  parameter int IW       = 8,
  parameter int GW       = 4,
  parameter int OW       = 12
);
  logic                   strobe;
  logic [CHANNELS*IW-1:0] sample;
  logic [CHANNELS*GW-1:0] gain;
  logic [CHANNELS*2-1:0]  pan;
  logic [OW-1:0]          left;
  logic [OW-1:0]          right;
  logic                   valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output strobe, sample, gain, pan,
    input  left, right, valid, busy, overrun
  );

  modport slave (
    input  strobe, sample, gain, pan,
    output left, right, valid, busy, overrun
  );
endinterface

// File: rtl/audio_sat.sv
// rtl/audio_sat.sv - right shift followed by unsigned clip to OW bits
module audio_sat #(
  parameter int AW    = 15,
  parameter int SHIFT = 3,
  parameter int OW    = 12
) (
  input  logic [AW-1:0] acc,
  output logic [OW-1:0] y
);
  logic [AW-1:0] shifted;

  assign shifted = acc >> SHIFT;

  generate
    if (AW > OW) begin : g_clip
      assign y = (|shifted[AW-1:OW]) ? {OW{1'b1}} : shifted[OW-1:0];
    end else begin : g_pass
      assign y = OW'(shifted);
    end
  endgenerate
endmodule

// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - time-multiplexed stereo mixer, one channel accumulated per clock
module audio_mixer
  import audio_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int IW       = 8,
  parameter int GW       = 4,
  parameter int SHIFT    = 3,
  parameter int OW       = 12
) (
  input  logic          clock,
  input  logic          reset,
  audio_mixer_if.slave  bus
);
  localparam int AW = acc_width(IW, GW, CHANNELS);
  localparam int XW = clog2(CHANNELS);
  localparam logic [XW-1:0] LAST = XW'(CHANNELS - 1);

  state_t                 state, state_nx;
  logic [XW-1:0]          idx;
  logic [CHANNELS*IW-1:0] snap_sample;
  logic [CHANNELS*GW-1:0] snap_gain;
  logic [CHANNELS*2-1:0]  snap_pan;
  logic [AW-1:0]          acc_l, acc_r;
  logic [OW-1:0]          left_q, right_q, sat_l, sat_r;
  logic                   valid_q, overrun_q;
  logic                   load, step, emit, busy;
  logic [IW-1:0]          cur_sample;
  logic [GW-1:0]          cur_gain;
  logic [1:0]             cur_pan;
  logic [IW+GW-1:0]       prod;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.strobe) state_nx = ACC;
      ACC:     if (idx == LAST) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    emit = 1'b0;
    busy = 1'b0;
    unique case (state)
      IDLE:    load = bus.strobe;
      ACC:     begin step = 1'b1; busy = 1'b1; end
      OUT:     begin emit = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  assign cur_sample = snap_sample[idx*IW +: IW];
  assign cur_gain   = snap_gain[idx*GW +: GW];
  assign cur_pan    = snap_pan[idx*2 +: 2];
  assign prod       = (IW+GW)'(cur_sample) * (IW+GW)'(cur_gain);

  // Sources are frozen at acceptance so the mix is coherent even if they move mid-sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx         <= '0;
      snap_sample <= '0;
      snap_gain   <= '0;
      snap_pan    <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      valid_q <= emit;
      if (bus.strobe && state != IDLE) overrun_q <= 1'b1;
      if (load) begin
        snap_sample <= bus.sample;
        snap_gain   <= bus.gain;
        snap_pan    <= bus.pan;
        acc_l       <= '0;
        acc_r       <= '0;
        idx         <= '0;
      end
      if (step) begin
        if (cur_pan[0]) acc_l <= acc_l + AW'(prod);
        if (cur_pan[1]) acc_r <= acc_r + AW'(prod);
        if (idx != LAST) idx <= idx + XW'(1);
      end
      if (emit) begin
        left_q  <= sat_l;
        right_q <= sat_r;
      end
    end
  end

  audio_sat #(.AW(AW), .SHIFT(SHIFT), .OW(OW)) u_sat_l (.acc(acc_l), .y(sat_l));
  audio_sat #(.AW(AW), .SHIFT(SHIFT), .OW(OW)) u_sat_r (.acc(acc_r), .y(sat_r));

  assign bus.left    = left_q;
  assign bus.right   = right_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy;
  assign bus.overrun = overrun_q;
endmodule
